// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot select driver with a command handshake.
// Supports hold, continuous scan, and one-shot sweep with a done pulse.
module scan_decoder #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DWELL      = 1,
  localparam int unsigned N         = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  output logic [N-1:0]          out,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  wrap,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, HOLD, SCAN, SWEEP} state_t;
  typedef enum logic [1:0] {CMD_OFF, CMD_DIRECT, CMD_SCAN, CMD_SWEEP} cmd_t;

  localparam logic [15:0]           DWELL_LAST = 16'(DWELL - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE        = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   index_q, index_d;
  logic [ADDR_WIDTH-1:0]   start_q, start_d;
  logic [ADDR_WIDTH-1:0]   sweep_last;
  logic [15:0]             dwell_q, dwell_d;
  logic [N-1:0]            out_d;
  logic                    wrap_d, done_d;
  logic                    accept;

  assign cmd_ready  = (state_q != SWEEP);
  assign accept     = cmd_valid && cmd_ready;
  assign sweep_last = start_q - ONE;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    start_d = start_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      case (cmd_t'(cmd_mode))
        CMD_OFF:    state_d = IDLE;
        CMD_DIRECT: begin
          state_d = HOLD;
          index_d = cmd_address;
        end
        CMD_SCAN:   begin
          state_d = SCAN;
          index_d = cmd_address;
          dwell_d = '0;
        end
        default:    begin
          state_d = SWEEP;
          index_d = cmd_address;
          start_d = cmd_address;
          dwell_d = '0;
        end
      endcase
    end else if (enable && (state_q == SCAN || state_q == SWEEP)) begin
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        // Sweep completion replaces the step: index stays on the last visited line.
        if (state_q == SWEEP && index_q == sweep_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          index_d = index_q + ONE;
          wrap_d  = (index_q == '1);
        end
      end else begin
        dwell_d = dwell_q + 16'd1;
      end
    end
  end

  always_comb begin
    out_d = '0;
    if (enable && state_d != IDLE) out_d[index_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      index_q <= '0;
      start_q <= '0;
      dwell_q <= '0;
      out     <= '0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      start_q <= start_d;
      dwell_q <= dwell_d;
      out     <= out_d;
      wrap    <= wrap_d;
      done    <= done_d;
    end
  end

  assign index = index_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder (ADDR_WIDTH=2, DWELL=2): the stimulus queues
// hand-computed per-edge expectations, and a monitor pops and compares them after each edge.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [1:0] cmd_address = 2'd0;
  logic [3:0] out;
  logic [1:0] index;
  logic       wrap, done;

  int tests = 0;
  int fails = 0;
  int step_no = 0;

  typedef struct {
    int         id;
    logic [3:0] o;
    logic [1:0] i;
    logic       w, d, r;
  } exp_t;

  exp_t q[$];

  scan_decoder #(.ADDR_WIDTH(2), .DWELL(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_address(cmd_address), .out(out), .index(index),
    .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step%0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("out",       e.id, 32'(out),       32'(e.o));
    check("index",     e.id, 32'(index),     32'(e.i));
    check("wrap",      e.id, 32'(wrap),      32'(e.w));
    check("done",      e.id, 32'(done),      32'(e.d));
    check("cmd_ready", e.id, 32'(cmd_ready), 32'(e.r));
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_all(e);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the coming edge.
  task automatic cyc(input logic v, input logic [1:0] m, input logic [1:0] a,
                     input logic en, input logic [3:0] eo, input logic [1:0] ei,
                     input logic ew, input logic ed, input logic er);
    exp_t e;
    @(negedge clk);
    cmd_valid   = v;
    cmd_mode    = m;
    cmd_address = a;
    enable      = en;
    step_no++;
    e.id = step_no; e.o = eo; e.i = ei; e.w = ew; e.d = ed; e.r = er;
    q.push_back(e);
  endtask

  initial begin
    exp_t e0;
    #1;
    e0.id = 0; e0.o = 4'b0000; e0.i = 2'd0; e0.w = 0; e0.d = 0; e0.r = 1;
    check_all(e0);
    @(negedge clk);
    reset_n = 1'b1;

    //   v  mode   addr en  out      idx w d r
    cyc(1, 2'b01, 2'd2, 1, 4'b0100, 2'd2, 0, 0, 1); // DIRECT 2
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 1);
    cyc(1, 2'b00, 2'd0, 1, 4'b0000, 2'd2, 0, 0, 1); // OFF, index holds
    cyc(1, 2'b10, 2'd3, 1, 4'b1000, 2'd3, 0, 0, 1); // SCAN from 3
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b0001, 2'd0, 1, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b0001, 2'd0, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b0010, 2'd1, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b0010, 2'd1, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 0, 4'b0000, 2'd2, 0, 0, 1); // enable low x3
    cyc(0, 2'b00, 2'd0, 0, 4'b0000, 2'd2, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 0, 4'b0000, 2'd2, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 1); // same dwell phase
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 1);
    cyc(0, 2'b00, 2'd0, 1, 4'b0001, 2'd0, 1, 0, 1); // period 8 wrap
    cyc(1, 2'b01, 2'd1, 1, 4'b0010, 2'd1, 0, 0, 1); // back-to-back DIRECT 1
    cyc(1, 2'b10, 2'd0, 1, 4'b0001, 2'd0, 0, 0, 1); // then SCAN 0
    cyc(0, 2'b00, 2'd0, 1, 4'b0001, 2'd0, 0, 0, 1);
    cyc(1, 2'b11, 2'd1, 1, 4'b0010, 2'd1, 0, 0, 0); // SWEEP from 1
    cyc(1, 2'b01, 2'd3, 1, 4'b0010, 2'd1, 0, 0, 0); // DIRECT ignored
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0001, 2'd0, 1, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0001, 2'd0, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0000, 2'd0, 0, 1, 1); // done
    cyc(0, 2'b00, 2'd0, 1, 4'b0000, 2'd0, 0, 0, 1);
    cyc(1, 2'b11, 2'd2, 1, 4'b0100, 2'd2, 0, 0, 0); // SWEEP from 2
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 0);

    // Asynchronous reset between edges, mid-sweep.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    e0.id = 100; e0.o = 4'b0000; e0.i = 2'd0; e0.w = 0; e0.d = 0; e0.r = 1;
    check_all(e0);
    @(negedge clk);
    reset_n = 1'b1;

    cyc(1, 2'b11, 2'd0, 1, 4'b0001, 2'd0, 0, 0, 0); // SWEEP from 0
    cyc(0, 2'b00, 2'd0, 1, 4'b0001, 2'd0, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0010, 2'd1, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0010, 2'd1, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0100, 2'd2, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b1000, 2'd3, 0, 0, 0);
    cyc(0, 2'b00, 2'd0, 1, 4'b0000, 2'd3, 0, 1, 1); // done, no wrap
    cyc(0, 2'b00, 2'd0, 1, 4'b0000, 2'd3, 0, 0, 1);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      fails++;
      tests++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Registered, parametrised N-to-2^N one-hot decoder with a command handshake and an auto-stepping scan engine. It drives select lines for banks of 2^ADDR_WIDTH targets (LED/display digits, memory banks, mux selects): it can hold one line, scan all lines continuously, or sweep each line exactly once and report completion. All outputs are registered, and the block is glitch-free by construction.

## Interface
Parameters:
- ADDR_WIDTH, default 2: address width; number of outputs N = 2**ADDR_WIDTH (local, derived).
- DWELL, default 1: cycles each output stays asserted in scan/sweep modes; legal range 1..65535.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  global gate; low forces out to zero and freezes stepping.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted; equals (state != SWEEP).
- cmd_mode  in  2  00 OFF, 01 DIRECT, 10 SCAN, 11 SWEEP.
- cmd_address  in  ADDR_WIDTH  DIRECT target, or SCAN/SWEEP start index.
- out  out  N  registered one-hot select, or all zero.
- index  out  ADDR_WIDTH  current selected index (registered).
- wrap  out  1  one-cycle pulse when index steps from N-1 to 0.
- done  out  1  one-cycle pulse when a SWEEP completes.

## Operation
- States: IDLE, HOLD, SCAN, SWEEP.
- A command is accepted on a rising edge with cmd_valid && cmd_ready. An accepted command always overrides the current state.
  - OFF: go to IDLE; index holds.
  - DIRECT: go to HOLD; index <= cmd_address.
  - SCAN: go to SCAN; index <= cmd_address, dwell counter <= 0.
  - SWEEP: go to SWEEP; index <= cmd_address, start <= cmd_address, dwell counter <= 0.
- out = onehot(index) when state is HOLD, SCAN or SWEEP and enable = 1 (registered); otherwise out = 0.
- Stepping (SCAN/SWEEP, enable = 1, no command accepted this edge):
  - If dwell == DWELL-1: dwell <= 0, index <= index+1 mod N.
  - Otherwise dwell <= dwell+1.
- wrap = 1 on the cycle after any step from N-1 to 0.
- SWEEP ends at the dwell expiry of index (start-1) mod N. On that edge: state <= IDLE, out <= 0, done <= 1, index holds at the last visited value. If that step also crosses N-1 to 0, wrap is not asserted (no step occurs).
- enable = 0: out register loads 0; dwell and index freeze; commands are still accepted and update state/index. On enable returning to 1, out resumes onehot(index) on the next edge and dwell counting continues from its frozen value.
- Commands are ignored while in SWEEP (cmd_ready = 0). cmd_ready rises in the cycle after the done edge.
- Reset (asynchronous, at any time including mid-sweep): state IDLE, out 0, index 0, dwell 0, start 0, wrap 0, done 0. cmd_ready is 1 immediately after reset asserts.

## Timing
- Command to out latency: 1 cycle (out reflects the new command in the cycle after the accept edge).
- SCAN period: N*DWELL cycles per full cycle; wrap has period N*DWELL.
- SWEEP duration: exactly N*DWELL cycles with out non-zero, then done for 1 cycle; frozen (enable = 0) cycles extend this 1:1.
- out never has two bits set; every transition is a single-edge registered change.

## Test plan
- Reset, then DIRECT addr=2 (ADDR_WIDTH=2) -> out=0100 and index=2 one cycle later. OFF -> out=0000, index stays 2.
- SCAN start=3, DWELL=2 -> out sequence 1000,1000,0001,0001,0010,... with wrap pulsing on the cycle out first shows 0001, repeating every 8 cycles.
- SWEEP start=1, DWELL=1 -> out 0010,0100,1000,0001, then 0000 with done=1 for one cycle. cmd_ready=0 throughout the sweep and 1 after. A DIRECT command presented mid-sweep is not accepted.
- Drop enable for 3 cycles mid-SCAN -> out=0000 for those cycles, index frozen, stepping resumes with the same dwell phase.
- Assert reset_n low mid-SWEEP (asynchronously, between edges) -> out, wrap and done are 0 immediately, cmd_ready=1, index=0.
- Back-to-back commands (DIRECT 1, then SCAN 0 on the next cycle) -> out 0010 then 0001, with no gap or overlap.
